// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store initiator and dmem_responder.
// The initiator drives the request side; the responder drives results.
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] memAddr;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic        Done;
  logic        Stall;
  logic        err;

  modport master (
    output MemRead,
    output MemWrite,
    output memAddr,
    output writeData,
    input  readData,
    input  Done,
    input  Stall,
    input  err
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  memAddr,
    input  writeData,
    output readData,
    output Done,
    output Stall,
    output err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency 16-bit data memory responder with IDLE/BUSY/DONE sequencing.
// Illegal requests complete on time with err set and leave state untouched.
module dmem_responder #(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [2:0] CNT_LOAD =
    (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  state_t                state;
  state_t                state_nx;
  logic [2:0]            cnt;
  logic [2:0]            cnt_nx;

  logic [DEPTH_LOG2-1:0] idx_q;
  logic [15:0]           wdata_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  odd_q;

  logic                  req;
  logic                  accept;
  logic                  commit;
  logic                  from_busy;

  logic [DEPTH_LOG2-1:0] c_idx;
  logic [15:0]           c_wdata;
  logic                  c_rd;
  logic                  c_wr;
  logic                  c_odd;
  logic                  c_bad;

  logic [15:0]           mem [WORDS];
  logic [15:0]           rdata_q;
  logic                  done_q;
  logic                  err_q;

  logic                  unused_addr_hi;

  assign unused_addr_hi = ^bus.memAddr[15:DEPTH_LOG2+1];

  assign req    = bus.MemRead | bus.MemWrite;
  assign accept = req && (state != BUSY);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE, DONE: begin
        if (!accept) begin
          state_nx = IDLE;
        end else if (LATENCY == 1) begin
          state_nx = DONE;
        end else begin
          state_nx = BUSY;
          cnt_nx   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == 3'd0) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // With LATENCY=1 the commit edge is the accept edge, so use live inputs.
  assign from_busy = (state == BUSY);
  assign commit    = (state_nx == DONE);

  always_comb begin
    c_idx   = bus.memAddr[DEPTH_LOG2:1];
    c_wdata = bus.writeData;
    c_rd    = bus.MemRead;
    c_wr    = bus.MemWrite;
    c_odd   = bus.memAddr[0];
    if (from_busy) begin
      c_idx   = idx_q;
      c_wdata = wdata_q;
      c_rd    = rd_q;
      c_wr    = wr_q;
      c_odd   = odd_q;
    end
  end

  assign c_bad = (c_rd & c_wr) | c_odd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      wdata_q <= 16'h0000;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      odd_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= bus.memAddr[DEPTH_LOG2:1];
      wdata_q <= bus.writeData;
      rd_q    <= bus.MemRead;
      wr_q    <= bus.MemWrite;
      odd_q   <= bus.memAddr[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= 16'h0000;
      end
    end else if (commit && c_wr && !c_bad) begin
      mem[c_idx] <= c_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 16'h0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= commit;
      err_q  <= commit & c_bad;
      if (commit && c_rd && !c_bad) begin
        rdata_q <= mem[c_idx];
      end
    end
  end

  assign bus.readData = rdata_q;
  assign bus.Done     = done_q;
  assign bus.err      = err_q;
  assign bus.Stall    = from_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level model at LATENCY=2,
// plus directed timing checks on LATENCY=1 and LATENCY=7 builds.
module tb_dmem_responder;

  localparam int ML = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  dmem_responder_if a ();
  dmem_responder_if b ();
  dmem_responder_if c ();

  dmem_responder #(.LATENCY(2), .DEPTH_LOG2(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  dmem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut_l1 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  dmem_responder #(.LATENCY(7), .DEPTH_LOG2(8)) dut_l7 (
    .clk (clk),
    .rst (rst),
    .bus (c)
  );

  always #5 clk = ~clk;

  // Reference: a transaction accepted in cycle t finishes in cycle t+ML.
  logic [15:0] m_mem [256];
  logic [15:0] m_rdata;
  logic [15:0] m_addr;
  logic [15:0] m_data;
  bit          m_rd;
  bit          m_wr;
  bit          m_pend;
  int          m_done_cyc;
  int          cyc;
  bit          e_done;
  bit          e_err;
  bit          e_stall;

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
    m_rdata = 16'h0000;
    m_pend  = 1'b0;
    e_done  = 1'b0;
    e_err   = 1'b0;
    e_stall = 1'b0;
    cyc     = 0;
    m_done_cyc = 0;
  endtask

  initial begin
    bit bad;
    logic [7:0] idx;
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_clear();
      end else begin
        e_done = 1'b0;
        e_err  = 1'b0;
        if (!(m_pend && cyc < m_done_cyc) &&
            (a.MemRead || a.MemWrite)) begin
          m_pend = 1'b1;
          m_rd   = a.MemRead;
          m_wr   = a.MemWrite;
          m_addr = a.memAddr;
          m_data = a.writeData;
          m_done_cyc = cyc + ML;
        end
        if (m_pend && m_done_cyc == cyc + 1) begin
          bad = (m_rd && m_wr) || m_addr[0];
          idx = m_addr[8:1];
          if (!bad) begin
            if (m_wr) m_mem[idx] = m_data;
            if (m_rd) m_rdata = m_mem[idx];
          end
          e_done = 1'b1;
          e_err  = bad;
          m_pend = 1'b0;
        end
        cyc++;
        e_stall = m_pend && cyc < m_done_cyc;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if (a.Done !== e_done || a.Stall !== e_stall ||
          a.readData !== m_rdata ||
          (e_done && a.err !== e_err)) begin
        miscompares++;
        $display("FAIL cycle t=%0t Done=%b/%b Stall=%b/%b err=%b/%b rd=%h/%h",
                 $time, a.Done, e_done, a.Stall, e_stall,
                 a.err, e_err, a.readData, m_rdata);
      end
    end
  end

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(bit rd, bit wr,
                       logic [15:0] addr, logic [15:0] data);
    int k;
    a.MemRead   = rd;
    a.MemWrite  = wr;
    a.memAddr   = addr;
    a.writeData = data;
    k = 0;
    while (a.Stall && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("issue_stall_bound", 16'(a.Stall), 16'h0);
    @(posedge clk);
    #1;
    a.MemRead   = 1'b0;
    a.MemWrite  = 1'b0;
    a.memAddr   = 16'($urandom);
    a.writeData = 16'($urandom);
  endtask

  task automatic wait_done(output int n,
                           output logic [15:0] rdata, output logic e);
    n = 0;
    rdata = 16'h0000;
    e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (a.Done) begin
        n = i;
        rdata = a.readData;
        e = a.err;
        break;
      end
    end
    vectors++;
    if (n == 0) begin
      miscompares++;
      $display("FAIL done_timeout: got no Done expected Done within 20");
    end
  endtask

  task automatic xact(string nm, bit rd, bit wr,
                      logic [15:0] addr, logic [15:0] data,
                      output logic [15:0] rdata, output logic e);
    int n;
    issue(rd, wr, addr, data);
    wait_done(n, rdata, e);
    chk({nm, "_latency"}, 16'(n), 16'(ML));
  endtask

  initial begin
    logic [15:0] rv;
    logic        ev;
    logic [15:0] addr;
    int          n;
    int          n1;
    int          n7;
    int          cnt7;
    bit          stall1;
    bit          stall7;
    int          r;

    a.MemRead = 0; a.MemWrite = 0; a.memAddr = 0; a.writeData = 0;
    b.MemRead = 0; b.MemWrite = 0; b.memAddr = 0; b.writeData = 0;
    c.MemRead = 0; c.MemWrite = 0; c.memAddr = 0; c.writeData = 0;

    repeat (3) @(negedge clk);
    chk("rst_done", 16'(a.Done), 16'h0);
    chk("rst_stall", 16'(a.Stall), 16'h0);
    chk("rst_rdata", a.readData, 16'h0000);
    rst = 1'b0;

    // LATENCY=1 and LATENCY=7 builds
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk);
      #1;
      b.MemRead  = (pass == 1); b.MemWrite = (pass == 0);
      c.MemRead  = (pass == 1); c.MemWrite = (pass == 0);
      b.memAddr  = 16'h0004;    c.memAddr  = 16'h0004;
      b.writeData = 16'h5A5A;   c.writeData = 16'h5A5A;
      @(posedge clk);
      #1;
      b.MemRead = 0; b.MemWrite = 0; b.writeData = 16'h0000;
      c.MemRead = 0; c.MemWrite = 0; c.writeData = 16'h0000;
      n1 = 0; n7 = 0; cnt7 = 0; stall1 = 0; stall7 = 0;
      for (int i = 1; i <= 12; i++) begin
        @(negedge clk);
        if (b.Done && n1 == 0) n1 = i;
        if (c.Done && n7 == 0) n7 = i;
        if (c.Done) cnt7++;
        stall1 |= b.Stall;
        if (i == 3) stall7 = c.Stall;
        if (c.Done && pass == 1)
          chk("l7_rdata", c.readData, 16'h5A5A);
        if (b.Done && pass == 1)
          chk("l1_rdata", b.readData, 16'h5A5A);
      end
      chk("l1_latency", 16'(n1), 16'd1);
      chk("l7_latency", 16'(n7), 16'd7);
      chk("l7_one_pulse", 16'(cnt7), 16'd1);
      chk("l1_never_stall", 16'(stall1), 16'h0);
      chk("l7_stall_mid", 16'(stall7), 16'h1);
    end

    // write then read back
    issue(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("beef_stall_c1", 16'(a.Stall), 16'h1);
    wait_done(n, rv, ev);
    chk("beef_wr_latency", 16'(n), 16'd2);
    chk("beef_wr_err", 16'(ev), 16'h0);
    xact("beef_rd", 1'b1, 1'b0, 16'h0010, 16'h0000, rv, ev);
    chk("beef_rd_data", rv, 16'hBEEF);

    // back-to-back from DONE
    xact("b2b_wr", 1'b0, 1'b1, 16'h0020, 16'h1234, rv, ev);
    xact("b2b_rd", 1'b1, 1'b0, 16'h0020, 16'h0000, rv, ev);
    chk("b2b_rd_data", rv, 16'h1234);

    // illegal requests
    xact("odd_rd", 1'b1, 1'b0, 16'h0011, 16'h0000, rv, ev);
    chk("odd_rd_err", 16'(ev), 16'h1);
    chk("odd_rd_keep", rv, 16'h1234);
    xact("both", 1'b1, 1'b1, 16'h0030, 16'hFFFF, rv, ev);
    chk("both_err", 16'(ev), 16'h1);
    xact("both_rd", 1'b1, 1'b0, 16'h0030, 16'h0000, rv, ev);
    chk("both_rd_data", rv, 16'h0000);
    chk("both_rd_err", 16'(ev), 16'h0);

    // aliasing
    xact("alias_wr", 1'b0, 1'b1, 16'h0202, 16'hA5A5, rv, ev);
    xact("alias_rd", 1'b1, 1'b0, 16'h0002, 16'h0000, rv, ev);
    chk("alias_rd_data", rv, 16'hA5A5);

    // abort in BUSY
    issue(1'b0, 1'b1, 16'h0040, 16'h7777);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_done", 16'(a.Done), 16'h0);
    chk("abort_stall", 16'(a.Stall), 16'h0);
    chk("abort_rdata", a.readData, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    cnt7 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a.Done) cnt7++;
    end
    chk("abort_no_done", 16'(cnt7), 16'h0);
    xact("abort_rd", 1'b1, 1'b0, 16'h0040, 16'h0000, rv, ev);
    chk("abort_rd_data", rv, 16'h0000);

    // request held through reset
    @(negedge clk);
    rst = 1'b1;
    a.MemWrite = 1'b1;
    a.memAddr = 16'h0002;
    a.writeData = 16'h0ABC;
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 1'b1, 16'h0002, 16'h0ABC);
    wait_done(n, rv, ev);
    chk("held_latency", 16'(n), 16'd2);
    xact("held_rd", 1'b1, 1'b0, 16'h0002, 16'h0000, rv, ev);
    chk("held_rd_data", rv, 16'h0ABC);

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 99);
      addr = 16'($urandom);
      addr[8:1] = 8'($urandom_range(0, 15));
      addr[0] = ($urandom_range(0, 99) < 12);
      if (r < 10)
        issue(1'b1, 1'b1, addr, 16'($urandom));
      else if (r < 55)
        issue(1'b0, 1'b1, addr, 16'($urandom));
      else
        issue(1'b1, 1'b0, addr, 16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $fatal(1, "watchdog");
  end

endmodule
